// File: rtl/shared_memory_multi.sv
// Register-file memory with a pattern generator, one external writer and
// NUM_READERS independent one-cycle-latency read channels.

module shared_memory_multi_rd #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         req,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
    output logic [WIDTH-1:0]             data,
    output logic                         valid
);
    // Sampled before any same-edge write lands, so a colliding read sees old data.
    always_ff @(posedge clock) begin
        if (clear) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= req;
            if (req) data <= mem[addr];
        end
    end
endmodule

module shared_memory_multi #(
    parameter  int WIDTH       = 4,
    parameter  int DEPTH       = 8,
    parameter  int NUM_READERS = 2,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          gen_en,
    output logic                          gen_wrap,
    input  logic [NUM_READERS-1:0]        rd_req,
    input  logic [NUM_READERS*ADDR_W-1:0] rd_addr,
    output logic [NUM_READERS*WIDTH-1:0]  rd_data,
    output logic [NUM_READERS-1:0]        rd_valid
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state, state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic [WIDTH-1:0]             pat;
    logic [ADDR_W-1:0]            gen_ptr;
    logic                         gen_write;

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // The generator acts in the cycle gen_en is seen, so N cycles of gen_en give N writes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gen_en)  state_nxt = RUN;
            RUN:     if (!gen_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        gen_write = (state_nxt == RUN) && !wr_en;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            mem      <= '0;
            pat      <= '0;
            gen_ptr  <= '0;
            gen_wrap <= 1'b0;
        end else begin
            gen_wrap <= gen_write && (gen_ptr == ADDR_W'(DEPTH - 1));
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end else if (gen_write) begin
                mem[gen_ptr] <= pat;
                pat          <= {~pat[WIDTH-2:0], 1'b0};
                gen_ptr      <= gen_ptr + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_READERS; i++) begin : g_rd
        shared_memory_multi_rd #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .clock (clock),
            .clear (clear),
            .req   (rd_req[i]),
            .addr  (rd_addr[i*ADDR_W +: ADDR_W]),
            .mem   (mem),
            .data  (rd_data[i*WIDTH +: WIDTH]),
            .valid (rd_valid[i])
        );
    end
endmodule

// File: tb/tb_shared_memory_multi.sv
// Directed scenarios plus random traffic against an array-based reference model.

module tb_shared_memory_multi;
    localparam int W  = 4;
    localparam int D  = 8;
    localparam int NR = 2;
    localparam int AW = 3;

    logic             clock = 1'b0;
    logic             clear, wr_en, gen_en, gen_wrap;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     wr_data;
    logic [NR-1:0]    rd_req, rd_valid;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*W-1:0]  rd_data;

    int checks   = 0;
    int failures = 0;

    int              m_mem [D];
    int              m_pat, m_ptr;
    logic            m_wrap;
    logic [NR*W-1:0] m_rd;
    logic [NR-1:0]   m_vld;

    always #5 clock = ~clock;

    shared_memory_multi #(.WIDTH(W), .DEPTH(D), .NUM_READERS(NR)) dut (
        .clock    (clock),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .gen_en   (gen_en),
        .gen_wrap (gen_wrap),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    task automatic model_edge();
        if (clear) begin
            foreach (m_mem[k]) m_mem[k] = 0;
            m_pat = 0; m_ptr = 0; m_wrap = 1'b0; m_rd = '0; m_vld = '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (rd_req[i]) begin
                    m_rd[i*W +: W] = W'(m_mem[rd_addr[i*AW +: AW]]);
                    m_vld[i] = 1'b1;
                end else begin
                    m_vld[i] = 1'b0;
                end
            end
            m_wrap = gen_en && !wr_en && (m_ptr == D - 1);
            if (wr_en) begin
                m_mem[wr_addr] = int'(wr_data);
            end else if (gen_en) begin
                m_mem[m_ptr] = m_pat;
                m_pat = ((~m_pat) << 1) & ((1 << W) - 1);
                m_ptr = (m_ptr + 1) % D;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic clr, input logic we, input logic [AW-1:0] wa,
                        input logic [W-1:0] wd, input logic ge, input logic [NR-1:0] rq,
                        input logic [NR*AW-1:0] ra);
        @(negedge clock);
        clear = clr; wr_en = we; wr_addr = wa; wr_data = wd;
        gen_en = ge; rd_req = rq; rd_addr = ra;
        @(posedge clock);
        model_edge();
        #1;
        check("rd_data",  32'(rd_data),  32'(m_rd));
        check("rd_valid", 32'(rd_valid), 32'(m_vld));
        check("gen_wrap", 32'(gen_wrap), 32'(m_wrap));
    endtask

    task automatic do_clear();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic gen(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b1, '0, '0);
    endtask

    task automatic rd2(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 2'b11, {a1, a0});
    endtask

    initial begin
        clear = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        gen_en = 1'b0; rd_req = '0; rd_addr = '0;

        // reset state
        do_clear();
        check("reset_rd_data", 32'(rd_data), 32'h0);
        check("reset_rd_valid", 32'(rd_valid), 32'h0);

        // four generator writes
        gen(4);
        rd2(3'd1, 3'd0);
        check("gen4_mem01", 32'(rd_data), 32'hE0);
        rd2(3'd3, 3'd2);
        check("gen4_mem23", 32'(rd_data), 32'hA2);
        rd2(3'd4, 3'd4);
        check("gen4_mem4_untouched", 32'(rd_data), 32'h00);

        // wrap pulse after write to last address, pointer back at 0
        do_clear();
        gen(7);
        check("wrap_low_before", 32'(gen_wrap), 32'h0);
        gen(1);
        check("wrap_pulse", 32'(gen_wrap), 32'h1);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        check("wrap_one_cycle", 32'(gen_wrap), 32'h0);
        gen(1);
        rd2(3'd7, 3'd0);
        check("wrap_ptr_zero", 32'(rd_data), 32'hAA);

        // external write stalls the generator
        do_clear();
        gen(3);
        step(1'b0, 1'b1, 3'd5, 4'b1001, 1'b1, '0, '0);
        gen(1);
        rd2(3'd4, 3'd3);
        check("stall_resume", 32'(rd_data), 32'h0A);
        rd2(3'd5, 3'd5);
        check("stall_ext_write", 32'(rd_data), 32'h99);

        // read-during-write returns old data
        do_clear();
        gen(3);
        step(1'b0, 1'b1, 3'd2, 4'b0111, 1'b0, 2'b11, {3'd2, 3'd2});
        check("rdw_old_data", 32'(rd_data), 32'h22);
        check("rdw_valid", 32'(rd_valid), 32'h3);
        rd2(3'd2, 3'd2);
        check("rdw_new_data", 32'(rd_data), 32'h77);

        // clear mid-run overrides everything and wipes memory
        do_clear();
        gen(3);
        step(1'b1, 1'b1, 3'd6, 4'hF, 1'b1, 2'b11, {3'd1, 3'd0});
        check("midclr_rd_data", 32'(rd_data), 32'h0);
        check("midclr_rd_valid", 32'(rd_valid), 32'h0);
        gen(1);
        rd2(3'd1, 3'd0);
        check("midclr_restart", 32'(rd_data), 32'h00);
        rd2(3'd6, 3'd1);
        check("midclr_no_write", 32'(rd_data), 32'h00);

        // single-channel request then release: data holds, valid drops
        do_clear();
        gen(2);
        step(1'b0, 1'b0, '0, '0, 1'b0, 2'b01, {3'd0, 3'd1});
        check("ch0_valid", 32'(rd_valid), 32'h1);
        check("ch0_data", 32'(rd_data), 32'h0E);
        step(1'b0, 1'b0, '0, '0, 1'b0, 2'b00, {3'd0, 3'd0});
        check("ch0_valid_drop", 32'(rd_valid), 32'h0);
        check("ch0_data_hold", 32'(rd_data), 32'h0E);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 32) == 0, ($urandom % 4) == 0, AW'($urandom), W'($urandom),
                 ($urandom % 3) != 0, NR'($urandom), (NR*AW)'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
